// File: rtl/rs485_pkg.sv
// Shared RS485 link definitions: receiver states, frame geometry and address/data flag values.
package rs485_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        FLAG,
        STOP,
        BREAK
    } rx_state_t;

    localparam int         FRAME_DATA_BITS = 8;
    localparam logic [7:0] BCAST_ADDR      = 8'hFF;
    localparam logic       FLAG_ADDR       = 1'b1;
    localparam logic       FLAG_DATA       = 1'b0;

    // True when an address byte selects this node, optionally via the broadcast address.
    function automatic logic is_addr_hit(input logic [7:0] addr,
                                         input logic [7:0] slave_addr,
                                         input logic       bcast_en);
        return (addr == slave_addr) || (bcast_en && (addr == BCAST_ADDR));
    endfunction

endpackage

// File: rtl/rs485_rx_frame_decoder_if.sv
// Rx line, driver-enable blanking and decoded frame outputs of the RS485 receiver.
// master is the decoder side; slave is the line driver / frame consumer side.
interface rs485_rx_frame_decoder_if;
    logic       rx;
    logic       tx_enable;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       rx_valid;
    logic       addr_match;
    logic       frame_error;
    logic       busy;

    modport master (
        input  rx,
        input  tx_enable,
        output rx_data,
        output rx_flag,
        output rx_valid,
        output addr_match,
        output frame_error,
        output busy
    );

    modport slave (
        output rx,
        output tx_enable,
        input  rx_data,
        input  rx_flag,
        input  rx_valid,
        input  addr_match,
        input  frame_error,
        input  busy
    );
endinterface

// File: rtl/rs485_rx_sync.sv
// Two-flop synchroniser with falling-edge detect; idles high so reset never fakes an edge.
// Latency: dout 2 clocks after din, fall same cycle as dout drops; no backpressure.
module rs485_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;
endmodule

// File: rtl/rs485_rx_frame_decoder.sv
// Oversampling RS485 multidrop receiver: start, 8 data LSB first, addr/data flag, stop.
// Latency: rx_valid ~3 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT clocks after start edge; no backpressure.
module rs485_rx_frame_decoder
    import rs485_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 50,
    parameter logic [7:0] SLAVE_ADDR   = 8'h01,
    parameter bit         BCAST_EN     = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    rs485_rx_frame_decoder_if.master  bus
);
    localparam int             CW        = 10;
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(FRAME_DATA_BITS - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          flag_q, flag_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_flag_q, rx_flag_d;
    logic          valid_q, valid_d;
    logic          match_q, match_d;
    logic          err_q, err_d;

    logic rx_s;
    logic rx_fall;
    logic tick_half;
    logic tick_bit;

    rs485_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.rx),
        .dout    (rx_s),
        .fall    (rx_fall)
    );

    assign tick_half = (bit_cnt_q == HALF_LAST);
    assign tick_bit  = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            flag_q    <= 1'b0;
            rx_data_q <= '0;
            rx_flag_q <= 1'b0;
            valid_q   <= 1'b0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            flag_q    <= flag_d;
            rx_data_q <= rx_data_d;
            rx_flag_q <= rx_flag_d;
            valid_q   <= valid_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        flag_d    = flag_q;
        rx_data_d = rx_data_q;
        rx_flag_d = rx_flag_q;
        valid_d   = 1'b0;
        match_d   = 1'b0;
        err_d     = 1'b0;

        // Our own driver is on the bus: whatever we hear is our echo, drop it.
        if (bus.tx_enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            idx_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    if (rx_fall) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_half) begin
                        bit_cnt_d = '0;
                        state_d   = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_bit) begin
                        bit_cnt_d = '0;
                        shreg_d   = {rx_s, shreg_q[7:1]};
                        idx_d     = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = FLAG;
                        end
                    end
                end
                FLAG: begin
                    if (tick_bit) begin
                        bit_cnt_d = '0;
                        flag_d    = rx_s;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        bit_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            rx_flag_d = flag_q;
                            valid_d   = 1'b1;
                            match_d   = (flag_q == FLAG_ADDR) &&
                                        is_addr_hit(shreg_q, SLAVE_ADDR, BCAST_EN);
                            state_d   = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Need a full bit time of continuous idle before trusting edges again.
                    if (!rx_s) begin
                        bit_cnt_d = '0;
                    end else if (tick_bit) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_flag     = rx_flag_q;
    assign bus.rx_valid    = valid_q;
    assign bus.addr_match  = match_q;
    assign bus.frame_error = err_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_rs485_rx_frame_decoder.sv
// Bench for rs485_rx_frame_decoder: directed scenarios plus random frames against a frame-level model.
module tb_rs485_rx_frame_decoder;
    import rs485_pkg::*;

    localparam int         C     = 16;
    localparam logic [7:0] SLAVE = 8'h01;
    localparam int         LAT   = 3 + C / 2 + 10 * C;

    typedef struct {
        logic       err;
        logic [7:0] data;
        logic       flag;
        logic       match;
        int         cyc;
    } ev_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   viol    = 0;
    int   busy_cnt = 0;
    logic pv_a    = 1'b0;
    logic pv_b    = 1'b0;
    ev_t  obs_a[$];
    ev_t  obs_b[$];
    logic [7:0] m_data = 8'h00;
    logic       m_flag = 1'b0;

    always #5 clk = ~clk;

    rs485_rx_frame_decoder_if dif ();
    rs485_rx_frame_decoder_if bif ();

    assign bif.rx        = dif.rx;
    assign bif.tx_enable = dif.tx_enable;

    rs485_rx_frame_decoder #(.CLKS_PER_BIT(C), .SLAVE_ADDR(SLAVE), .BCAST_EN(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.master)
    );

    rs485_rx_frame_decoder #(.CLKS_PER_BIT(C), .SLAVE_ADDR(SLAVE), .BCAST_EN(1'b1)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dif.rx_valid || dif.frame_error)
            obs_a.push_back('{dif.frame_error, dif.rx_data, dif.rx_flag, dif.addr_match, cyc});
        if (bif.rx_valid || bif.frame_error)
            obs_b.push_back('{bif.frame_error, bif.rx_data, bif.rx_flag, bif.addr_match, cyc});
        if (dif.rx_valid && dif.frame_error) viol++;
        if (bif.rx_valid && bif.frame_error) viol++;
        if (dif.addr_match && !dif.rx_valid) viol++;
        if (bif.addr_match && !bif.rx_valid) viol++;
        if ((dif.rx_valid || dif.frame_error) && pv_a) viol++;
        if ((bif.rx_valid || bif.frame_error) && pv_b) viol++;
        pv_a = dif.rx_valid || dif.frame_error;
        pv_b = bif.rx_valid || bif.frame_error;
        if (dif.busy) busy_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_tests++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 11-bit frame; abort_at >= 0 raises tx_enable that many clocks into the frame.
    task automatic send(input logic [7:0] d, input logic f, input logic stop,
                        input int abort_at, output int t0);
        logic [10:0] bits;
        bits = {stop, f, d, 1'b0};
        t0   = cyc;
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < C; k++) begin
                dif.rx = bits[i];
                if (i * C + k == abort_at) dif.tx_enable = 1'b1;
                if (abort_at >= 0 && i * C + k == abort_at + 1)
                    chk("abort_busy_drop", 32'(dif.busy), 32'd0);
                @(negedge clk);
            end
        end
        dif.rx = 1'b1;
    endtask

    task automatic check_ev(input string tag, input int inst, input logic [7:0] d,
                            input logic f, input logic stop, input int t0);
        ev_t  e;
        logic exp_m;
        int   n;
        n = (inst == 0) ? obs_a.size() : obs_b.size();
        chk({tag, "_count"}, 32'(n), 32'd1);
        if (n > 0) begin
            if (inst == 0) e = obs_a.pop_front();
            else           e = obs_b.pop_front();
            exp_m = stop && (f == FLAG_ADDR) &&
                    ((d == SLAVE) || ((inst == 1) && (d == BCAST_ADDR)));
            chk({tag, "_err"}, 32'(e.err), 32'(!stop));
            chk({tag, "_match"}, 32'(e.match), 32'(exp_m));
            if (stop) begin
                chk({tag, "_data"}, 32'(e.data), 32'(d));
                chk({tag, "_flag"}, 32'(e.flag), 32'(f));
            end
            chk_rng({tag, "_latency"}, e.cyc - t0, LAT - 1, LAT + 1);
        end
        if (inst == 0) obs_a.delete();
        else           obs_b.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic f, input logic stop);
        int t0;
        send(d, f, stop, -1, t0);
        check_ev(tag, 0, d, f, stop, t0);
        check_ev({tag, "_b"}, 1, d, f, stop, t0);
        if (stop) begin
            m_data = d;
            m_flag = f;
        end
        chk({tag, "_rx_data"}, 32'(dif.rx_data), 32'(m_data));
        chk({tag, "_rx_flag"}, 32'(dif.rx_flag), 32'(m_flag));
    endtask

    initial begin
        int         t0;
        logic [7:0] d;
        logic       f;
        logic       stop;

        dif.rx        = 1'b1;
        dif.tx_enable = 1'b0;
        reset_n       = 1'b0;
        idle(3);
        chk("rst_rx_data", 32'(dif.rx_data), 32'h0);
        chk("rst_rx_flag", 32'(dif.rx_flag), 32'h0);
        chk("rst_rx_valid", 32'(dif.rx_valid), 32'h0);
        chk("rst_addr_match", 32'(dif.addr_match), 32'h0);
        chk("rst_frame_error", 32'(dif.frame_error), 32'h0);
        chk("rst_busy", 32'(dif.busy), 32'h0);
        reset_n = 1'b1;
        idle(2 * C);

        run_frame("addr01", 8'h01, 1'b1, 1'b1);
        idle(C);

        run_frame("b2b_addr02", 8'h02, 1'b1, 1'b1);
        run_frame("b2b_dataA5", 8'hA5, 1'b0, 1'b1);
        idle(C);

        busy_cnt = 0;
        dif.rx = 1'b0;
        idle(4);
        dif.rx = 1'b1;
        idle(2 * C);
        chk_rng("glitch_busy_len", busy_cnt, C / 2 - 1, C / 2 + 1);
        chk("glitch_no_event", 32'(obs_a.size() + obs_b.size()), 32'd0);

        send(8'h01, 1'b1, 1'b0, -1, t0);
        dif.rx = 1'b0;
        idle(24);
        dif.rx = 1'b1;
        check_ev("stop0", 0, 8'h01, 1'b1, 1'b0, t0);
        check_ev("stop0_b", 1, 8'h01, 1'b1, 1'b0, t0);
        chk("stop0_rx_data_hold", 32'(dif.rx_data), 32'(m_data));
        idle(10);
        chk("break_still_busy", 32'(dif.busy), 32'd1);
        idle(20);
        chk("break_exit", 32'(dif.busy), 32'd0);
        run_frame("after_break", 8'h01, 1'b1, 1'b1);
        idle(C);

        send(8'h01, 1'b1, 1'b1, 5 * C + C / 2, t0);
        idle(C);
        send(8'h01, 1'b1, 1'b1, -1, t0);
        idle(C);
        dif.tx_enable = 1'b0;
        idle(2 * C);
        chk("txen_no_event", 32'(obs_a.size() + obs_b.size()), 32'd0);
        chk("txen_rx_data_hold", 32'(dif.rx_data), 32'(m_data));

        run_frame("bcast_ff", 8'hFF, 1'b1, 1'b1);
        idle(C);

        dif.rx = 1'b0;
        idle(3 * C);
        chk("midframe_busy", 32'(dif.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_rx_data", 32'(dif.rx_data), 32'h0);
        chk("async_rst_rx_flag", 32'(dif.rx_flag), 32'h0);
        chk("async_rst_busy", 32'(dif.busy), 32'h0);
        chk("async_rst_busy_b", 32'(bif.busy), 32'h0);
        chk("async_rst_pulses", 32'({dif.rx_valid, dif.addr_match, dif.frame_error}), 32'h0);
        m_data = 8'h00;
        m_flag = 1'b0;
        dif.rx = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(2 * C);
        chk("rst_no_event", 32'(obs_a.size() + obs_b.size()), 32'd0);
        run_frame("post_reset", 8'h01, 1'b1, 1'b1);
        idle(C);

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 3))
                0:       d = 8'h01;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            f    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            run_frame("rnd", d, f, stop);
            if (!stop)
                idle(2 * C + $urandom_range(0, C - 1));
            else if ($urandom_range(0, 2) != 0)
                idle($urandom_range(1, 2 * C));
        end
        idle(2 * C);

        chk("pulse_invariants", 32'(viol), 32'd0);
        chk("no_leftover_events", 32'(obs_a.size() + obs_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
